// File: rtl/avalon_ram_slave.sv
// Avalon-MM word RAM slave with programmable wait states, byte enables and a sticky error flag.
// Optional RANDOM_WAIT_EN: per-access wait count taken from a 16-bit LFSR instead of WAIT_CYCLES.
module avalon_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_err
);

    localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          req;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [3:0]    load_val;
    logic          enter_resp;
    logic          mem_we;
    logic          unused_bits;

    assign req         = read | write;
    assign offset      = address - BASE_ADDR;
    assign in_range    = (address >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign idx         = offset[AW+1:2];
    assign unused_bits = ^{offset[1:0], offset[31:AW+2]};

`ifdef RANDOM_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign load_val = lfsr_q[3:0];

    // Fibonacci form of x^16+x^14+x^13+x^11+1, stepped once per accepted request
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == StIdle && req) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign load_val = 4'(WAIT_CYCLES);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        bus_err_d  = bus_err_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    cnt_d = load_val;
                    if (load_val != 4'd0) begin
                        state_d = StWait;
                    end else begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end
                end
            end
            StWait: begin
                if (!req) begin
                    // master dropped its request before it was accepted
                    state_d   = StIdle;
                    cnt_d     = 4'd0;
                    bus_err_d = 1'b1;
                end else if (cnt_q <= 4'd1) begin
                    state_d    = StResp;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                mem_we  = write && in_range;
            end
            default: state_d = StIdle;
        endcase

        if (enter_resp) begin
            if (!in_range || (read && write)) begin
                bus_err_d = 1'b1;
            end
            if (read && !write) begin
                readdata_d = in_range ? mem_q[idx] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            readdata_q <= 32'h0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Storage is never cleared by reset; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    mem_q[idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    assign waitrequest = req && (state_q != StResp);
    assign readdata    = readdata_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Self-checking bench: three slaves (1, 3 and 0 wait cycles) driven by directed and random accesses.
module tb_avalon_ram_slave;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic [31:0] addr  [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [31:0] wdata [3];
    logic [3:0]  be    [3];
    logic        wreq  [3];
    logic [31:0] rdata [3];
    logic        berr  [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [16];

    always #5 clk = ~clk;

    avalon_ram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .reset(rst[0]), .address(addr[0]), .read(rd[0]), .write(wr[0]),
        .writedata(wdata[0]), .byteenable(be[0]), .waitrequest(wreq[0]),
        .readdata(rdata[0]), .bus_err(berr[0])
    );

    avalon_ram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .WAIT_CYCLES(3)) u1 (
        .clk(clk), .reset(rst[1]), .address(addr[1]), .read(rd[1]), .write(wr[1]),
        .writedata(wdata[1]), .byteenable(be[1]), .waitrequest(wreq[1]),
        .readdata(rdata[1]), .bus_err(berr[1])
    );

    avalon_ram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .WAIT_CYCLES(0)) u2 (
        .clk(clk), .reset(rst[2]), .address(addr[2]), .read(rd[2]), .write(wr[2]),
        .writedata(wdata[2]), .byteenable(be[2]), .waitrequest(wreq[2]),
        .readdata(rdata[2]), .bus_err(berr[2])
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int u);
        rd[u] = 1'b0;
        wr[u] = 1'b0;
    endtask

    task automatic pulse_reset(input int u);
        rst[u] = 1'b1;
        tick(1);
        rst[u] = 1'b0;
    endtask

    // Starts just after a rising edge, returns just after the edge closing the low-waitrequest cycle
    // with the request still driven (so a following call is back-to-back).
    task automatic access(input int u, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output int stall, output logic [31:0] q);
        bit got;
        got   = 1'b0;
        stall = 0;
        q     = 32'hx;
        rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d; be[u] = b;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (wreq[u] !== 1'b1) begin
                got = 1'b1;
                q   = rdata[u];
            end else begin
                stall++;
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL access_timeout u%0d addr %h: waitrequest never fell", u, a);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) rst[u] = 1'b1;
        tick(2);
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b0;
            checks++; if (wreq[u] !== 1'b0) begin errors++;
                $display("FAIL reset_waitreq u%0d got %b want 0", u, wreq[u]); end
            checks++; if (rdata[u] !== 32'h0) begin errors++;
                $display("FAIL reset_readdata u%0d got %h want 0", u, rdata[u]); end
            checks++; if (berr[u] !== 1'b0) begin errors++;
                $display("FAIL reset_bus_err u%0d got %b want 0", u, berr[u]); end
        end
    endtask

    task automatic test_basic();
        int s; logic [31:0] q;
        access(0, 0, 1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, s, q);
        checks++; if (s !== 2) begin errors++; $display("FAIL basic_wr_stall got %0d want 2", s); end
        access(0, 1, 0, BASE + 32'h10, 32'h0, 4'h0, s, q);
        checks++; if (s !== 2) begin errors++; $display("FAIL basic_rd_stall got %0d want 2", s); end
        checks++; if (q !== 32'hDEADBEEF) begin errors++;
            $display("FAIL basic_rd_data got %h want deadbeef", q); end
        access(0, 1, 0, BASE + 32'h13, 32'h0, 4'h0, s, q);
        checks++; if (q !== 32'hDEADBEEF) begin errors++;
            $display("FAIL low_bits_ignored got %h want deadbeef", q); end
        idle(0);
        tick(1);
        access(0, 0, 1, BASE + 32'hFFC, 32'h0BADF00D, 4'hF, s, q);
        access(0, 1, 0, BASE + 32'hFFC, 32'h0, 4'h0, s, q);
        idle(0);
        checks++; if (q !== 32'h0BADF00D) begin errors++;
            $display("FAIL last_word got %h want 0badf00d", q); end
        checks++; if (berr[0] !== 1'b0) begin errors++;
            $display("FAIL basic_no_err got %b want 0", berr[0]); end
        tick(1);
    endtask

    task automatic test_byte_enable();
        int s; logic [31:0] q;
        access(0, 0, 1, BASE + 32'h20, 32'h11223344, 4'hF, s, q);
        access(0, 0, 1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101, s, q);
        access(0, 1, 0, BASE + 32'h20, 32'h0, 4'h0, s, q);
        checks++; if (q !== 32'h11BB33DD) begin errors++;
            $display("FAIL be_0101 got %h want 11bb33dd", q); end
        access(0, 0, 1, BASE + 32'h20, 32'hFFFFFFFF, 4'b0000, s, q);
        access(0, 1, 0, BASE + 32'h20, 32'h0, 4'h0, s, q);
        idle(0);
        checks++; if (q !== 32'h11BB33DD) begin errors++;
            $display("FAIL be_0000 got %h want 11bb33dd", q); end
        tick(1);
    endtask

    task automatic test_random();
        int s; logic [31:0] q, d, a; logic [3:0] b; int i;
        for (int k = 0; k < 16; k++) begin
            mdl[k] = $urandom;
            access(0, 0, 1, BASE + 32'(4 * k), mdl[k], 4'hF, s, q);
        end
        for (int n = 0; n < 40; n++) begin
            i = $urandom_range(15);
            a = BASE + 32'(4 * i) + 32'($urandom_range(3));
            if ($urandom_range(1) == 1) begin
                d = $urandom;
                b = 4'($urandom_range(15));
                for (int k = 0; k < 4; k++) if (b[k]) mdl[i][8*k +: 8] = d[8*k +: 8];
                access(0, 0, 1, a, d, b, s, q);
            end else begin
                access(0, 1, 0, a, 32'h0, 4'h0, s, q);
                checks++; if (q !== mdl[i]) begin errors++;
                    $display("FAIL rand_rd word %0d got %h want %h", i, q, mdl[i]); end
            end
            checks++; if (s !== 2) begin errors++;
                $display("FAIL rand_stall op %0d got %0d want 2", n, s); end
            if ($urandom_range(1) == 1) begin
                idle(0);
                tick(1);
            end
        end
        idle(0);
        checks++; if (berr[0] !== 1'b0) begin errors++;
            $display("FAIL rand_no_err got %b want 0", berr[0]); end
        tick(1);
    endtask

    task automatic test_back_to_back();
        int s; logic [31:0] q;
        access(2, 0, 1, BASE + 32'h8, 32'h12345678, 4'hF, s, q);
        checks++; if (s !== 1) begin errors++; $display("FAIL w0_wr_stall got %0d want 1", s); end
        access(2, 1, 0, BASE + 32'h8, 32'h0, 4'h0, s, q);
        checks++; if (s !== 1) begin errors++; $display("FAIL w0_b2b_stall got %0d want 1", s); end
        checks++; if (q !== 32'h12345678) begin errors++;
            $display("FAIL w0_b2b_data got %h want 12345678", q); end
        access(2, 1, 0, BASE + 32'h9, 32'h0, 4'h0, s, q);
        idle(2);
        checks++; if (s !== 1) begin errors++; $display("FAIL w0_b2b2_stall got %0d want 1", s); end
        access(1, 0, 1, BASE + 32'h4, 32'hCAFE0001, 4'hF, s, q);
        checks++; if (s !== 4) begin errors++; $display("FAIL w3_wr_stall got %0d want 4", s); end
        access(1, 1, 0, BASE + 32'h4, 32'h0, 4'h0, s, q);
        idle(1);
        checks++; if (s !== 4) begin errors++; $display("FAIL w3_rd_stall got %0d want 4", s); end
        checks++; if (q !== 32'hCAFE0001) begin errors++;
            $display("FAIL w3_rd_data got %h want cafe0001", q); end
        tick(1);
    endtask

    task automatic test_out_of_range();
        int s; logic [31:0] q;
        access(0, 1, 0, 32'h00000000, 32'h0, 4'h0, s, q);
        checks++; if (s !== 2) begin errors++; $display("FAIL oor_rd_stall got %0d want 2", s); end
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h want 0", q); end
        checks++; if (berr[0] !== 1'b1) begin errors++;
            $display("FAIL oor_bus_err got %b want 1", berr[0]); end
        access(0, 1, 0, BASE - 32'h4, 32'h0, 4'h0, s, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL below_base got %h want 0", q); end
        access(0, 0, 1, BASE + 32'h1000, 32'hFFFFFFFF, 4'hF, s, q);
        checks++; if (s !== 2) begin errors++; $display("FAIL oor_wr_stall got %0d want 2", s); end
        access(0, 1, 0, BASE, 32'h0, 4'h0, s, q);
        idle(0);
        checks++; if (q !== mdl[0]) begin errors++;
            $display("FAIL oor_wr_dropped got %h want %h", q, mdl[0]); end
        tick(1);
    endtask

    task automatic test_read_write_both();
        int s; logic [31:0] q;
        pulse_reset(0);
        checks++; if (berr[0] !== 1'b0) begin errors++;
            $display("FAIL rw_reset_err got %b want 0", berr[0]); end
        access(0, 1, 0, BASE + 32'h4, 32'h0, 4'h0, s, q);
        checks++; if (q !== mdl[1]) begin errors++;
            $display("FAIL mem_kept_reset got %h want %h", q, mdl[1]); end
        access(0, 1, 1, BASE, 32'h5, 4'hF, s, q);
        checks++; if (q !== mdl[1]) begin errors++;
            $display("FAIL rw_rdata_held got %h want %h", q, mdl[1]); end
        checks++; if (berr[0] !== 1'b1) begin errors++;
            $display("FAIL rw_bus_err got %b want 1", berr[0]); end
        access(0, 1, 0, BASE, 32'h0, 4'h0, s, q);
        idle(0);
        checks++; if (q !== 32'h5) begin errors++; $display("FAIL rw_written got %h want 5", q); end
        tick(1);
    endtask

    task automatic test_protocol_violation();
        int s; logic [31:0] q;
        pulse_reset(1);
        rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = BASE + 32'h4; wdata[1] = 32'h0; be[1] = 4'hF;
        tick(1);
        wr[1] = 1'b0;
        tick(1);
        checks++; if (berr[1] !== 1'b1) begin errors++;
            $display("FAIL abandon_bus_err got %b want 1", berr[1]); end
        access(1, 1, 0, BASE + 32'h4, 32'h0, 4'h0, s, q);
        idle(1);
        checks++; if (q !== 32'hCAFE0001) begin errors++;
            $display("FAIL abandon_no_write got %h want cafe0001", q); end
        checks++; if (s !== 4) begin errors++; $display("FAIL abandon_stall got %0d want 4", s); end
        tick(1);
    endtask

    task automatic test_reset_mid_access();
        int s; logic [31:0] q;
        pulse_reset(1);
        rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = BASE + 32'h4; wdata[1] = 32'h99999999; be[1] = 4'hF;
        tick(2);
        rst[1] = 1'b1;
        tick(1);
        rst[1] = 1'b0;
        wr[1]  = 1'b0;
        @(negedge clk);
        checks++; if (wreq[1] !== 1'b0) begin errors++;
            $display("FAIL midrst_waitreq got %b want 0", wreq[1]); end
        checks++; if (berr[1] !== 1'b0) begin errors++;
            $display("FAIL midrst_bus_err got %b want 0", berr[1]); end
        @(posedge clk);
        #1;
        access(1, 1, 0, BASE + 32'h4, 32'h0, 4'h0, s, q);
        idle(1);
        checks++; if (q !== 32'hCAFE0001) begin errors++;
            $display("FAIL midrst_no_write got %h want cafe0001", q); end
        checks++; if (s !== 4) begin errors++; $display("FAIL midrst_stall got %0d want 4", s); end
        tick(1);
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; rd[u] = 1'b0; wr[u] = 1'b0;
            addr[u] = 32'h0; wdata[u] = 32'h0; be[u] = 4'h0;
        end
        tick(1);
        test_reset();
        test_basic();
        test_byte_enable();
        test_random();
        test_back_to_back();
        test_out_of_range();
        test_read_write_both();
        test_protocol_violation();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
